// File: rtl/temp_hyst_monitor.sv
// temp_hyst_monitor: per-channel threshold monitor with hysteresis band,
// consecutive-sample debounce, sticky alarms and a change-event stream.
module temp_hyst_monitor #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DEBOUNCE = 2,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_ch,
  input  logic                cfg_sel,
  input  logic [WIDTH-1:0]    cfg_data,
  input  logic                sample_valid,
  input  logic [CW-1:0]       sample_ch,
  input  logic [WIDTH-1:0]    sample_data,
  input  logic [CHANNELS-1:0] clr_sticky,
  output logic [CHANNELS-1:0] warn,
  output logic                warn_any,
  output logic [CHANNELS-1:0] alarm_sticky,
  output logic                event_valid,
  output logic [CW-1:0]       event_ch,
  output logic                event_rise
);

  localparam int DCW = $clog2(DEBOUNCE + 1);
  localparam logic [CW:0]  NCH = (CW + 1)'(CHANNELS);
  localparam logic [DCW:0] DEB = (DCW + 1)'(DEBOUNCE);

  logic [WIDTH-1:0]    hi_q  [CHANNELS];
  logic [WIDTH-1:0]    lo_q  [CHANNELS];
  logic [DCW-1:0]      cnt_q [CHANNELS];
  logic [DCW-1:0]      cnt_d [CHANNELS];
  logic [CHANNELS-1:0] st_q;
  logic [CHANNELS-1:0] st_d;
  logic [CHANNELS-1:0] rise_d;
  logic                cfg_ok;
  logic                smp_ok;
  logic                qual;
  logic                fire;

  assign cfg_ok = cfg_we && ({1'b0, cfg_ch} < NCH);
  assign smp_ok = sample_valid && ({1'b0, sample_ch} < NCH);
  assign warn   = st_q;

  // Compares use the registered thresholds, so a same-cycle write
  // only affects samples from the next cycle on.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    qual  = 1'b0;
    fire  = 1'b0;
    if (smp_ok) begin
      if (st_q[sample_ch])
        qual = sample_data < lo_q[sample_ch];
      else
        qual = sample_data > hi_q[sample_ch];
      if (!qual) begin
        cnt_d[sample_ch] = '0;
      end else if ({1'b0, cnt_q[sample_ch]} + 1'b1 == DEB) begin
        st_d[sample_ch]  = ~st_q[sample_ch];
        cnt_d[sample_ch] = '0;
        fire             = 1'b1;
      end else begin
        cnt_d[sample_ch] = cnt_q[sample_ch] + 1'b1;
      end
    end
    rise_d = st_d & ~st_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        hi_q[i]  <= '1;
        lo_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      st_q         <= '0;
      warn_any     <= 1'b0;
      alarm_sticky <= '0;
      event_valid  <= 1'b0;
      event_ch     <= '0;
      event_rise   <= 1'b0;
    end else begin
      if (cfg_ok) begin
        if (cfg_sel)
          hi_q[cfg_ch] <= cfg_data;
        else
          lo_q[cfg_ch] <= cfg_data;
      end
      cnt_q        <= cnt_d;
      st_q         <= st_d;
      warn_any     <= |st_d;
      // Set wins over a same-edge clear.
      alarm_sticky <= (alarm_sticky & ~clr_sticky) | rise_d;
      event_valid  <= fire;
      if (fire) begin
        event_ch   <= sample_ch;
        event_rise <= ~st_q[sample_ch];
      end
    end
  end

endmodule

// File: tb/tb_temp_hyst_monitor.sv
// tb_temp_hyst_monitor: directed vectors, expected responses queued
// by the stimulus and checked by an independent monitor.
module tb_temp_hyst_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic        cfg_sel = 1'b0;
  logic [15:0] cfg_data = '0;
  logic        sample_valid = 1'b0;
  logic [1:0]  sample_ch = '0;
  logic [15:0] sample_data = '0;
  logic [3:0]  clr_sticky = '0;
  logic [3:0]  warn;
  logic        warn_any;
  logic [3:0]  alarm_sticky;
  logic        event_valid;
  logic [1:0]  event_ch;
  logic        event_rise;

  temp_hyst_monitor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_sel      (cfg_sel),
    .cfg_data     (cfg_data),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sample_data  (sample_data),
    .clr_sticky   (clr_sticky),
    .warn         (warn),
    .warn_any     (warn_any),
    .alarm_sticky (alarm_sticky),
    .event_valid  (event_valid),
    .event_ch     (event_ch),
    .event_rise   (event_rise)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [3:0] w;
    logic [3:0] s;
    logic       ev;
  } st_rec_t;

  typedef struct {
    logic [1:0] ch;
    logic       rise;
  } ev_rec_t;

  st_rec_t sb[$];
  ev_rec_t evq[$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  logic        p_we = 1'b0;
  logic [1:0]  p_ch = '0;
  logic        p_sel = 1'b0;
  logic [15:0] p_data = '0;
  logic [3:0]  p_clr = '0;
  logic        p_rst = 1'b0;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares the DUT against queued expectations.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].tag == cyc) begin
        st_rec_t r;
        r = sb.pop_front();
        chk("warn", 16'(warn), 16'(r.w));
        chk("warn_any", 16'(warn_any), 16'(|r.w));
        chk("sticky", 16'(alarm_sticky), 16'(r.s));
        chk("event_valid", 16'(event_valid), 16'(r.ev));
      end
      if (event_valid === 1'b1) begin
        if (evq.size() == 0) begin
          chk("unexpected_event", 16'(event_valid), 16'h0);
        end else begin
          ev_rec_t e;
          e = evq.pop_front();
          chk("event_ch", 16'(event_ch), 16'(e.ch));
          chk("event_rise", 16'(event_rise), 16'(e.rise));
        end
      end
    end
  end

  task automatic step(input logic v, input logic [1:0] ch,
                      input logic [15:0] d, input logic [3:0] w,
                      input logic [3:0] s, input logic ev,
                      input logic [1:0] evch, input logic evr);
    st_rec_t r;
    ev_rec_t e;
    @(negedge clk);
    rst_n        = ~p_rst;
    cfg_we       = p_we;
    cfg_ch       = p_ch;
    cfg_sel      = p_sel;
    cfg_data     = p_data;
    clr_sticky   = p_clr;
    sample_valid = v;
    sample_ch    = ch;
    sample_data  = d;
    r.tag = cyc + 1;
    r.w   = w;
    r.s   = s;
    r.ev  = ev;
    sb.push_back(r);
    if (ev) begin
      e.ch   = evch;
      e.rise = evr;
      evq.push_back(e);
    end
    p_we  = 1'b0;
    p_clr = '0;
    p_rst = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic sel,
                     input logic [15:0] d);
    p_we   = 1'b1;
    p_ch   = ch;
    p_sel  = sel;
    p_data = d;
  endtask

  task automatic idle(input logic [3:0] w, input logic [3:0] s);
    step(1'b0, 2'd0, 16'h0, w, s, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic smp(input logic [1:0] ch, input logic [15:0] d,
                     input logic [3:0] w, input logic [3:0] s);
    step(1'b1, ch, d, w, s, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic smp_ev(input logic [1:0] ch, input logic [15:0] d,
                        input logic [3:0] w, input logic [3:0] s,
                        input logic evr);
    step(1'b1, ch, d, w, s, 1'b1, ch, evr);
  endtask

  initial begin
    p_rst = 1'b1; idle(4'h0, 4'h0);
    p_rst = 1'b1; idle(4'h0, 4'h0);
    // Defaults can never trip
    for (int i = 0; i < 4; i++) smp(2'd0, 16'hFFFF, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) smp(2'd0, 16'h0000, 4'h0, 4'h0);
    // ch1 rise with debounce
    cfg(2'd1, 1'b1, 16'h0400); idle(4'h0, 4'h0);
    cfg(2'd1, 1'b0, 16'h0300); idle(4'h0, 4'h0);
    smp(2'd1, 16'h0401, 4'h0, 4'h0);
    smp_ev(2'd1, 16'h0401, 4'h2, 4'h2, 1'b1);
    idle(4'h2, 4'h2);
    // Hysteresis band then fall
    for (int i = 0; i < 5; i++) smp(2'd1, 16'h0350, 4'h2, 4'h2);
    smp(2'd1, 16'h02FF, 4'h2, 4'h2);
    smp_ev(2'd1, 16'h02FF, 4'h0, 4'h2, 1'b0);
    idle(4'h0, 4'h2);
    p_clr = 4'b0010; idle(4'h0, 4'h0);
    idle(4'h0, 4'h0);
    // Debounce break on ch1
    smp(2'd1, 16'h0500, 4'h0, 4'h0);
    smp(2'd1, 16'h0100, 4'h0, 4'h0);
    smp(2'd1, 16'h0500, 4'h0, 4'h0);
    smp_ev(2'd1, 16'h0500, 4'h2, 4'h2, 1'b1);
    // ch2 set/clear collision, others isolated
    cfg(2'd2, 1'b1, 16'h0400); idle(4'h2, 4'h2);
    smp(2'd2, 16'h0500, 4'h2, 4'h2);
    p_clr = 4'b0100;
    smp_ev(2'd2, 16'h0500, 4'h6, 4'h6, 1'b1);
    p_clr = 4'b0100; idle(4'h6, 4'h2);
    // ch3 write/sample collision
    cfg(2'd3, 1'b1, 16'h0100); idle(4'h6, 4'h2);
    cfg(2'd3, 1'b1, 16'h0200); smp(2'd3, 16'h0150, 4'h6, 4'h2);
    smp(2'd3, 16'h0150, 4'h6, 4'h2);
    smp(2'd3, 16'h0150, 4'h6, 4'h2);
    // Reset mid-debounce drops the partial count
    cfg(2'd3, 1'b1, 16'h0100); idle(4'h6, 4'h2);
    smp(2'd3, 16'h0150, 4'h6, 4'h2);
    p_rst = 1'b1; idle(4'h0, 4'h0);
    smp(2'd1, 16'h0500, 4'h0, 4'h0);
    cfg(2'd3, 1'b1, 16'h0100); idle(4'h0, 4'h0);
    smp(2'd3, 16'h0150, 4'h0, 4'h0);
    smp_ev(2'd3, 16'h0150, 4'h8, 4'h8, 1'b1);
    idle(4'h8, 4'h8);
    idle(4'h8, 4'h8);
    repeat (3) @(negedge clk);
    chk("sb_drained", 16'(sb.size()), 16'h0);
    chk("evq_drained", 16'(evq.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/temp_hyst_monitor.md
# temp_hyst_monitor

Multi-channel threshold monitor with programmable hysteresis and sample debounce. It replaces the single-channel two-threshold warning path. Each channel has its own high/low thresholds, a NORMAL/WARN state, a consecutive-sample debounce counter, and a sticky alarm flag. It sits after the averaging stage: it consumes tagged averaged counts and drives the warning outputs, plus an event stream for the UART sender.

## Interface
Parameters:
- WIDTH, 16, bit width of samples and thresholds (unsigned)
- CHANNELS, 4, number of monitored channels (≥1)
- DEBOUNCE, 2, consecutive qualifying samples required to change state (≥1)
- CW, $clog2(CHANNELS) (min 1), channel index width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_we  in  1  threshold write strobe
- cfg_ch  in  CW  channel to write
- cfg_sel  in  1  0 = low threshold, 1 = high threshold
- cfg_data  in  WIDTH  threshold value
- sample_valid  in  1  sample strobe
- sample_ch  in  CW  sample channel
- sample_data  in  WIDTH  averaged count
- clr_sticky  in  CHANNELS  write-1-to-clear for the sticky flags
- warn  out  CHANNELS  per-channel state (1 = WARN)
- warn_any  out  1  OR of warn
- alarm_sticky  out  CHANNELS  set on a warn rise, held until cleared
- event_valid  out  1  one-cycle pulse on any state change
- event_ch  out  CW  channel that changed
- event_rise  out  1  1 = entered WARN, 0 = left WARN

## Operation
- Reset values:
  - high thresholds = all ones; low thresholds = 0.
  - All states NORMAL; all debounce counters 0.
  - warn, warn_any, alarm_sticky, event_valid, event_ch and event_rise = 0.
  - With these defaults no channel can ever change state.
- Threshold write: when cfg_we=1 and cfg_ch<CHANNELS, the threshold selected by cfg_sel is loaded. If cfg_ch≥CHANNELS the write is ignored.
- Samples: when sample_valid=1 and sample_ch<CHANNELS, the sample applies to that channel only. If sample_ch≥CHANNELS it is ignored. All other channels hold their state and counters.
- Qualifying sample (unsigned compare):
  - In NORMAL: sample_data > high.
  - In WARN: sample_data < low.
- Debounce, per accepted sample:
  - If the sample qualifies and counter+1 == DEBOUNCE: toggle the state, set the counter to 0, emit an event.
  - If the sample qualifies otherwise: increment the counter.
  - If the sample does not qualify: set the counter to 0.
  - Counter width is $clog2(DEBOUNCE+1). DEBOUNCE=1 means switching on the first qualifying sample.
- Band samples: a sample inside [low, high] never qualifies, so the state holds. This is the hysteresis band.
- Misconfiguration (low > high) is legal and not detected. The compare rules above apply unchanged.
- Sticky flag:
  - alarm_sticky[i] sets on the edge where warn[i] rises.
  - It clears on an edge where clr_sticky[i]=1.
  - If set and clear happen on the same edge, set wins.
- Event: event_valid pulses for exactly one cycle, with event_ch and event_rise valid in that cycle. Only one sample is accepted per cycle, so at most one event occurs per cycle. event_ch and event_rise hold their last values while event_valid=0.
- State update order: a threshold write and a sample on the same channel in the same cycle compare against the old threshold. The new value applies from the next cycle.

## Timing
- All outputs are registered.
- Latency: warn, warn_any, alarm_sticky and the event outputs update on the same rising edge that samples the final qualifying sample_valid, i.e. 1-cycle latency.
- Threshold write: takes effect on the edge where cfg_we is sampled.
- No backpressure: sample_valid is accepted every cycle and the block is never busy.
- Reset mid-debounce: rst_n=0 on an edge restores every reset value, including thresholds and counters. Partial counts are lost.

## Test plan
- Reset defaults: after reset, send 0xFFFF ×4 then 0x0000 ×4 on ch0 → warn stays 0 and no event_valid.
- Rise with debounce (ch1: high=0x0400, low=0x0300):
  - Send 0x0401 twice.
  - Required: warn[1]=1 and alarm_sticky[1]=1 on the edge sampling the second sample.
  - Required: event_valid=1 for one cycle with event_ch=1, event_rise=1; warn_any=1.
- Debounce break (ch1 NORMAL): send 0x0500, 0x0100, 0x0500 → warn[1] stays 0. A further 0x0500 → warn[1]=1.
- Hysteresis band and fall (ch1 in WARN):
  - 0x0350 ×5 → warn[1] stays 1.
  - Then 0x02FF ×2 → warn[1]=0 and an event with event_rise=0.
  - alarm_sticky[1] stays 1 until clr_sticky=4'b0010, then reads 0.
- Set/clear collision and channel isolation:
  - The second qualifying sample on ch2 coincides with clr_sticky[2]=1 → alarm_sticky[2]=1.
  - Samples with sample_ch=2 leave warn[0], warn[1] and warn[3] unchanged.
- Write/sample collision and reset mid-operation (ch3, high=0x0100, low=0x0000):
  - Write high=0x0200 in the same cycle as sample 0x0150 (cycle 1), then send 0x0150 in cycle 2.
  - Required: the counter counts only cycle 1, so warn[3] stays 0.
  - Reprogram high=0x0100 and send one 0x0150, then pulse rst_n=0 for 1 cycle.
  - Reprogram high=0x0100 again and send one 0x0150 → warn[3] stays 0, because the count restarted.
